// File: rtl/sram_bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sram_bridge_pkg
//  Description : Shared types and constants for the SRAM request bridge:
//                FSM state encoding and timeout counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package sram_bridge_pkg;

  // Bridge control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the optional mem_ack timeout counter (covers TIMEOUT up to 255)
  localparam int TIMER_W = 8;

endpackage : sram_bridge_pkg
`default_nettype wire

// File: rtl/sram_if.sv
`default_nettype none
// ============================================================================
//  Module      : sram (interface)
//  Description : Simple stall-based SRAM bus. The master drives en/we/addr/
//                data_w and holds them while stall is high; the responder
//                returns data_r and stall.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sram;
  logic        en;
  logic        we;
  logic [31:0] addr;
  logic [31:0] data_w;
  logic [31:0] data_r;
  logic        stall;

  modport master (output en, we, addr, data_w, input data_r, stall);
  modport slave  (input en, we, addr, data_w, output data_r, stall);
endinterface : sram
`default_nettype wire

// File: rtl/sram_bridge_timer.sv
`default_nettype none
// ============================================================================
//  Module      : bridge_timer
//  Description : Wait-cycle counter for the bridge. Cleared when an access
//                starts, advanced on every BUSY cycle that has no mem_ack.
//                expired fires in the cycle whose increment would make the
//                count reach TIMEOUT, so an access sees exactly TIMEOUT
//                unacknowledged BUSY cycles before being given up.
//  Revision    : 1.0 - initial release
// ============================================================================
module bridge_timer
  import sram_bridge_pkg::*;
#(
  parameter int TIMEOUT = 255
)(
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam logic [TIMER_W-1:0] LIMIT = TIMER_W'(TIMEOUT - 1);

  logic [TIMER_W-1:0] cnt;

  // Wait counter: clear at access start, step on each waiting cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (count) begin
      cnt <= cnt + TIMER_W'(1);
    end
  end

  assign expired = count && (cnt == LIMIT);

endmodule : bridge_timer
`default_nettype wire

// File: rtl/sram_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : sram_bridge
//  Description : Bridges a stall-based SRAM slave port to a registered
//                req/ack memory interface. Misaligned addresses and memory
//                errors raise a one-cycle err_valid pulse with err_addr.
//                Optional mem_ack timeout enabled by SRAM_BRIDGE_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_bridge
  import sram_bridge_pkg::*;
#(
  parameter int TIMEOUT = 255
)(
  input  logic        clk,
  input  logic        rst,
  sram.slave          bus,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  input  logic        mem_err,
  output logic        err_valid,
  output logic [31:0] err_addr
);

  state_t      state;
  logic [31:0] data_r_reg;
  logic        start;
  logic        misaligned;
  logic        busy_wait;
  logic        timeout;

  assign start      = (state == IDLE) && bus.en && (bus.addr[1:0] == 2'b00);
  assign misaligned = (state == IDLE) && bus.en && (bus.addr[1:0] != 2'b00);
  assign busy_wait  = (state == BUSY) && !mem_ack;

  // Stall holds the master from the request cycle until the access ends;
  // DONE always releases it so the master advances exactly once.
  assign bus.stall  = ((state == IDLE) && bus.en) || (state == BUSY);
  assign bus.data_r = data_r_reg;

`ifdef SRAM_BRIDGE_TIMEOUT_EN
  bridge_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (start),
    .count   (busy_wait),
    .expired (timeout)
  );
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0) && busy_wait;
  assign timeout        = 1'b0;
`endif

  // Main control FSM with registered memory-side and error outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      data_r_reg <= '0;
      err_valid  <= 1'b0;
      err_addr   <= '0;
    end else begin
      err_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mem_we    <= bus.we;
            mem_addr  <= bus.addr;
            mem_wdata <= bus.data_w;
            mem_req   <= 1'b1;
            state     <= BUSY;
          end else if (misaligned) begin
            err_valid <= 1'b1;
            err_addr  <= bus.addr;
            state     <= DONE;
          end
        end
        BUSY: begin
          // An ack always wins over a timeout landing in the same cycle
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= DONE;
            if (mem_err) begin
              err_valid <= 1'b1;
              err_addr  <= mem_addr;
            end else if (!mem_we) begin
              data_r_reg <= mem_rdata;
            end
          end else if (timeout) begin
            mem_req   <= 1'b0;
            err_valid <= 1'b1;
            err_addr  <= mem_addr;
            state     <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          mem_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule : sram_bridge
`default_nettype wire

// File: tb/tb_sram_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_bridge
//  Description : Self-checking bench for sram_bridge. Directed transactions
//                push their hand-computed outcome into a queue; a negedge
//                monitor measures each completed transaction and compares.
//                Timeout vectors run only with SRAM_BRIDGE_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_bridge;

  typedef struct {
    int          stall_n;
    int          req_n;
    logic        err;
    logic [31:0] err_addr;
    logic [31:0] data_r;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        mem_err = 1'b0;
  logic        err_valid;
  logic [31:0] err_addr;

  sram bus_if ();

  sram_bridge #(
    .TIMEOUT (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_if),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .mem_err   (mem_err),
    .err_valid (err_valid),
    .err_addr  (err_addr)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic        active = 1'b0;
  int          stall_n, req_n;
  logic        cap_valid, stable;
  logic        cap_we;
  logic [31:0] cap_addr, cap_wdata;
  int          err_pulses = 0;
  logic        prev_err = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      active   = 1'b0;
      prev_err = 1'b0;
    end else begin
      if (err_valid) begin
        err_pulses++;
        if (prev_err) check("err_pulse_width", 32'd2, 32'd1);
      end
      prev_err = err_valid;
      if (bus_if.stall) begin
        if (!active) begin
          active    = 1'b1;
          stall_n   = 0;
          req_n     = 0;
          cap_valid = 1'b0;
          stable    = 1'b1;
        end
        stall_n++;
        if (mem_req) begin
          req_n++;
          if (!cap_valid) begin
            cap_valid = 1'b1;
            cap_we    = mem_we;
            cap_addr  = mem_addr;
            cap_wdata = mem_wdata;
          end else if (mem_we !== cap_we || mem_addr !== cap_addr || mem_wdata !== cap_wdata) begin
            stable = 1'b0;
          end
        end
      end else if (active) begin
        active = 1'b0;
        if (exp_q.size() == 0) begin
          check("unexpected_completion", 32'(stall_n), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("stall_cycles", 32'(stall_n), 32'(e.stall_n));
          check("req_cycles",   32'(req_n),   32'(e.req_n));
          check("done_err_valid", {31'd0, err_valid}, {31'd0, e.err});
          check("done_err_addr", err_addr, e.err_addr);
          check("done_data_r", bus_if.data_r, e.data_r);
          check("done_mem_req", {31'd0, mem_req}, 32'd0);
          if (e.req_n > 0) begin
            check("mem_we",    {31'd0, cap_we}, {31'd0, e.we});
            check("mem_addr",  cap_addr, e.addr);
            check("mem_wdata", cap_wdata, e.wdata);
            check("req_fields_stable", {31'd0, stable}, 32'd1);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input int ack_at, input logic [31:0] rd, input logic e, input logic drop,
                     input int x_stall, input int x_req, input logic x_err,
                     input logic [31:0] x_eaddr, input logic [31:0] x_data);
    exp_t x;
    int   k;
    x.stall_n = x_stall; x.req_n = x_req; x.err = x_err; x.err_addr = x_eaddr;
    x.data_r = x_data; x.we = w; x.addr = a; x.wdata = d;
    exp_q.push_back(x);
    @(posedge clk); #1;
    bus_if.en = 1'b1; bus_if.we = w; bus_if.addr = a; bus_if.data_w = d;
    @(posedge clk); #1;
    k = 1;
    while (mem_req && k <= 50) begin
      if (drop) bus_if.en = 1'b0;
      if (k == ack_at) begin
        mem_ack = 1'b1; mem_rdata = rd; mem_err = e;
      end
      @(posedge clk); #1;
      mem_ack = 1'b0; mem_err = 1'b0; mem_rdata = '0;
      k++;
    end
    // now in DONE with en possibly still high; it must not be re-issued
    @(posedge clk); #1;
    bus_if.en = 1'b0;
  endtask

  int exp_pulses;

  initial begin
    bus_if.en = 1'b0; bus_if.we = 1'b0; bus_if.addr = '0; bus_if.data_w = '0;
    exp_pulses = 3;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_stall",     {31'd0, bus_if.stall}, 32'd0);
    check("rst_mem_req",   {31'd0, mem_req}, 32'd0);
    check("rst_data_r",    bus_if.data_r, 32'd0);
    check("rst_err_valid", {31'd0, err_valid}, 32'd0);
    check("rst_err_addr",  err_addr, 32'd0);

    //  we    addr          wdata         ack rdata         err  drop stall req err  err_addr      data_r
    txn(1'b0, 32'h0000_1000, 32'h0000_0000, 3, 32'hDEAD_BEEF, 1'b0, 1'b0, 4, 3, 1'b0, 32'h0,         32'hDEAD_BEEF);
    txn(1'b1, 32'h0000_2004, 32'h1234_5678, 1, 32'hAAAA_AAAA, 1'b0, 1'b0, 2, 1, 1'b0, 32'h0,         32'hDEAD_BEEF);
    txn(1'b0, 32'h0000_3002, 32'h0000_0000, 1, 32'h0,         1'b0, 1'b0, 1, 0, 1'b1, 32'h0000_3002, 32'hDEAD_BEEF);
    txn(1'b0, 32'h0000_4000, 32'h0000_0000, 2, 32'h1111_1111, 1'b1, 1'b0, 3, 2, 1'b1, 32'h0000_4000, 32'hDEAD_BEEF);
    txn(1'b0, 32'h0000_5008, 32'h0000_0000, 1, 32'hCAFE_F00D, 1'b0, 1'b0, 2, 1, 1'b0, 32'h0000_4000, 32'hCAFE_F00D);
    txn(1'b0, 32'h0000_6000, 32'h0000_0000, 3, 32'h0BAD_F00D, 1'b0, 1'b1, 4, 3, 1'b0, 32'h0000_4000, 32'h0BAD_F00D);
    txn(1'b1, 32'h0000_7001, 32'h5555_5555, 1, 32'h0,         1'b0, 1'b0, 1, 0, 1'b1, 32'h0000_7001, 32'h0BAD_F00D);

    // stray ack while idle must be ignored
    @(posedge clk); #1;
    mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
    @(posedge clk); #1;
    mem_ack = 1'b0; mem_rdata = '0;
    @(negedge clk);
    check("idle_ack_data_r",  bus_if.data_r, 32'h0BAD_F00D);
    check("idle_ack_mem_req", {31'd0, mem_req}, 32'd0);
    check("idle_ack_stall",   {31'd0, bus_if.stall}, 32'd0);

`ifdef SRAM_BRIDGE_TIMEOUT_EN
    exp_pulses = 4;
    txn(1'b0, 32'h0000_8000, 32'h0000_0000, 0, 32'h0,         1'b0, 1'b0, 5, 4, 1'b1, 32'h0000_8000, 32'h0BAD_F00D);
    txn(1'b0, 32'h0000_9000, 32'h0000_0000, 4, 32'h55AA_55AA, 1'b0, 1'b0, 5, 4, 1'b0, 32'h0000_8000, 32'h55AA_55AA);
`endif

    // reset in the middle of an access, then a stray ack
    @(posedge clk); #1;
    bus_if.en = 1'b1; bus_if.we = 1'b0; bus_if.addr = 32'h0000_A000;
    @(posedge clk); #1;
    bus_if.en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_stall",     {31'd0, bus_if.stall}, 32'd0);
    check("midrst_mem_req",   {31'd0, mem_req}, 32'd0);
    check("midrst_data_r",    bus_if.data_r, 32'd0);
    check("midrst_err_valid", {31'd0, err_valid}, 32'd0);
    check("midrst_err_addr",  err_addr, 32'd0);
    @(posedge clk); #1;
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    mem_ack = 1'b0; mem_rdata = '0;
    @(negedge clk);
    check("stray_ack_data_r",  bus_if.data_r, 32'd0);
    check("stray_ack_mem_req", {31'd0, mem_req}, 32'd0);
    check("stray_ack_stall",   {31'd0, bus_if.stall}, 32'd0);

    repeat (3) @(posedge clk);
    check("pending_expectations", 32'(exp_q.size()), 32'd0);
    check("err_pulse_count", 32'(err_pulses), 32'(exp_pulses));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_sram_bridge
`default_nettype wire
